// File: rtl/dp_responder_pkg.sv
// rtl/dp_responder_pkg.sv - shared widths, opcodes, field positions and screen limits for dp_responder
package dp_responder_pkg;

  localparam int INSTR_WIDTH    = 32;
  localparam int MEM_ADDR_WIDTH = 8;
  localparam int DATA_WIDTH     = 16;
  localparam int RESULT_WIDTH   = DATA_WIDTH;
  localparam int X_COORD_WIDTH  = 8;
  localparam int Y_COORD_WIDTH  = 7;
  localparam int COLOUR_WIDTH   = 3;

  localparam int SCREEN_WIDTH  = 160;
  localparam int SCREEN_HEIGHT = 120;

  localparam logic [3:0] OPC_NOP      = 4'h0;
  localparam logic [3:0] OPC_MEMREAD  = 4'h1;
  localparam logic [3:0] OPC_MEMWRITE = 4'h2;
  localparam logic [3:0] OPC_DRAW     = 4'h3;

  localparam int ADDR_LSB    = 4;
  localparam int DATA_LSB    = 12;
  localparam int X_LSB       = 4;
  localparam int Y_LSB       = 12;
  localparam int COLOUR_LSB  = 19;
  localparam int PLOT_EN_BIT = 22;

  localparam logic [RESULT_WIDTH-1:0] ILLEGAL_RESULT = 16'hFFFF;

  typedef enum logic [2:0] {
    OP_NOP,
    OP_READ,
    OP_WRITE,
    OP_DRAW,
    OP_ILLEGAL
  } op_class_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RD_WAIT,
    ST_RD_CAP,
    ST_DONE
  } state_t;

  function automatic logic on_screen(input logic [X_COORD_WIDTH-1:0] x,
                                     input logic [Y_COORD_WIDTH-1:0] y);
    return (32'(x) < SCREEN_WIDTH) && (32'(y) < SCREEN_HEIGHT);
  endfunction

endpackage

// File: rtl/dp_decode.sv
// rtl/dp_decode.sv - combinational instruction field decode for dp_responder
module dp_decode
  import dp_responder_pkg::*;
(
  input  logic [INSTR_WIDTH-1:0]    instr,
  output op_class_t                 op_class,
  output logic [MEM_ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0]     data,
  output logic [X_COORD_WIDTH-1:0]  x,
  output logic [Y_COORD_WIDTH-1:0]  y,
  output logic [COLOUR_WIDTH-1:0]   colour,
  output logic                      plot_en
);

  logic unused_top_bits;

  always_comb begin
    op_class = OP_ILLEGAL;
    case (instr[3:0])
      OPC_NOP:      op_class = OP_NOP;
      OPC_MEMREAD:  op_class = OP_READ;
      OPC_MEMWRITE: op_class = OP_WRITE;
      OPC_DRAW:     op_class = OP_DRAW;
      default:      op_class = OP_ILLEGAL;
    endcase
  end

  // Fields overlap by design; only the ones relevant to op_class are consumed.
  assign addr    = instr[ADDR_LSB +: MEM_ADDR_WIDTH];
  assign data    = instr[DATA_LSB +: DATA_WIDTH];
  assign x       = instr[X_LSB +: X_COORD_WIDTH];
  assign y       = instr[Y_LSB +: Y_COORD_WIDTH];
  assign colour  = instr[COLOUR_LSB +: COLOUR_WIDTH];
  assign plot_en = instr[PLOT_EN_BIT];

  assign unused_top_bits = &{1'b0, instr[31:28]};

endmodule

// File: rtl/dp_responder.sv
// rtl/dp_responder.sv - single-instruction datapath responder (MEMREAD/MEMWRITE/DRAW); DP_CLIP_EN suppresses off-screen plots
module dp_responder
  import dp_responder_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [INSTR_WIDTH-1:0]    instruction,
  output logic                      finished,
  output logic [RESULT_WIDTH-1:0]   result,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic                      mem_we,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic [X_COORD_WIDTH-1:0]  vga_x,
  output logic [Y_COORD_WIDTH-1:0]  vga_y,
  output logic [COLOUR_WIDTH-1:0]   vga_colour,
  output logic                      vga_plot
);

  state_t                    state_q, state_d;
  logic                      armed_q, armed_d;
  logic [INSTR_WIDTH-1:0]    instr_q, instr_d;
  logic                      finished_q, finished_d;
  logic [RESULT_WIDTH-1:0]   result_q, result_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
  logic                      mem_we_q, mem_we_d;
  logic [X_COORD_WIDTH-1:0]  vga_x_q, vga_x_d;
  logic [Y_COORD_WIDTH-1:0]  vga_y_q, vga_y_d;
  logic [COLOUR_WIDTH-1:0]   vga_colour_q, vga_colour_d;
  logic                      vga_plot_q, vga_plot_d;

  op_class_t                 dec_class;
  logic [MEM_ADDR_WIDTH-1:0] dec_addr;
  logic [DATA_WIDTH-1:0]     dec_data;
  logic [X_COORD_WIDTH-1:0]  dec_x;
  logic [Y_COORD_WIDTH-1:0]  dec_y;
  logic [COLOUR_WIDTH-1:0]   dec_colour;
  logic                      dec_plot_en;
  logic                      plot_ok;

  dp_decode u_decode (
    .instr    (instr_q),
    .op_class (dec_class),
    .addr     (dec_addr),
    .data     (dec_data),
    .x        (dec_x),
    .y        (dec_y),
    .colour   (dec_colour),
    .plot_en  (dec_plot_en)
  );

`ifdef DP_CLIP_EN
  assign plot_ok = dec_plot_en & on_screen(dec_x, dec_y);
`else
  assign plot_ok = dec_plot_en;
`endif

  always_comb begin
    state_d      = state_q;
    armed_d      = armed_q;
    instr_d      = instr_q;
    finished_d   = finished_q;
    result_d     = result_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;

    // Re-arm only after start drops, so one held request runs once.
    if (!start) armed_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start && armed_q) begin
          instr_d    = instruction;
          finished_d = 1'b0;
          armed_d    = 1'b0;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (dec_class)
          OP_READ: begin
            mem_addr_d = dec_addr;
            state_d    = ST_RD_WAIT;
          end
          OP_WRITE: begin
            mem_addr_d  = dec_addr;
            mem_wdata_d = dec_data;
            mem_we_d    = 1'b1;
            state_d     = ST_DONE;
          end
          OP_DRAW: begin
            vga_x_d      = dec_x;
            vga_y_d      = dec_y;
            vga_colour_d = dec_colour;
            vga_plot_d   = plot_ok;
            state_d      = ST_DONE;
          end
          OP_NOP: begin
            result_d   = '0;
            finished_d = 1'b1;
            state_d    = ST_IDLE;
          end
          default: begin
            result_d   = ILLEGAL_RESULT;
            finished_d = 1'b1;
            state_d    = ST_IDLE;
          end
        endcase
      end
      ST_RD_WAIT: state_d = ST_RD_CAP;
      ST_RD_CAP: begin
        result_d   = mem_rdata;
        finished_d = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_DONE: begin
        result_d   = '0;
        finished_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      armed_q      <= 1'b1;
      instr_q      <= '0;
      finished_q   <= 1'b1;
      result_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      instr_q      <= instr_d;
      finished_q   <= finished_d;
      result_q     <= result_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
    end
  end

  assign finished   = finished_q;
  assign result     = result_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;

endmodule
